// File: rtl/fetch_queue_pkg.sv
// Shared fetch types: queue entry layout and the decoder key extraction.
package fetch_queue_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  // 18-bit decode key {funct7, instr[20], funct3, opcode}; the decoder bench uses it too
  function automatic logic [17:0] make_dec_key(input logic [31:0] instr);
    return {instr[31:25], instr[20], instr[14:12], instr[6:0]};
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: imem request/response, redirect input and decode handshake.
// master = fetch stage, slave = memory/decode/execute environment.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [17:0]     dec_key;
  logic [XLEN-1:0] dec_pc;
  logic            dec_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_key, dec_pc, dec_fault,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_key, dec_pc, dec_fault,
    output dec_ready
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; power-of-two depth, wrapping pointers plus a
// separate count so full/empty never alias. Push while full is accepted only
// together with a pop.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  // pointer/count next state; flush wins over push/pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // pointer/count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage needs no reset; entries are only visible through count
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the PC, issues word fetches under a credit
// limit so the queue can never overflow, buffers responses and hands them to
// decode. Redirects flush the queue and drop all older in-flight responses.
// Optional: FETCH_STALL_CNT_EN adds a saturating stall_cnt output counting
// cycles where decode is ready but the queue is empty.
module fetch_queue #(
  parameter int                 XLEN     = fetch_queue_pkg::XLEN,
  parameter int                 DEPTH    = 4,
  parameter logic [XLEN-1:0]    RESET_PC = fetch_queue_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);
  import fetch_queue_pkg::*;

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

  fetch_entry_t    push_ent, head_ent;
  logic [AW:0]     fifo_cnt;
  logic            fifo_empty;
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [AW:0]     out_q, out_d, disc_q, disc_d;
  logic            req_fire, rsp_push, dec_pop;

  assign redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // credit: queued + in flight must stay below DEPTH
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (({1'b0, fifo_cnt} + {1'b0, out_q}) < DEPTH_W);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_push = bus.imem_rsp_valid && (disc_q == '0) && !bus.redirect_valid;
  assign dec_pop  = bus.dec_valid && bus.dec_ready && !bus.redirect_valid;

  // responses return in order, so the PC of the next kept response is a counter
  assign push_ent = '{instr: bus.imem_rsp_data, pc: rsp_pc_q, fault: bus.imem_rsp_err};

  sync_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_iq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .pop_i   (dec_pop),
    .flush_i (bus.redirect_valid),
    .din_i   (push_ent),
    .dout_o  (head_ent),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign bus.dec_valid = !fifo_empty;
  assign bus.dec_instr = bus.dec_valid ? head_ent.instr : '0;
  assign bus.dec_pc    = bus.dec_valid ? head_ent.pc    : '0;
  assign bus.dec_fault = bus.dec_valid && head_ent.fault;
  assign bus.dec_key   = make_dec_key(bus.dec_instr);

  // PC, response-PC, outstanding and discard next state; redirect has priority
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    disc_d   = disc_q;
    if (bus.redirect_valid) begin
      pc_d     = redir_pc;
      rsp_pc_d = redir_pc;
      out_d    = out_q - CW'(bus.imem_rsp_valid);
      disc_d   = out_d;
    end else begin
      if (req_fire) pc_d     = pc_q + XLEN'(4);
      if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(4);
      out_d = out_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (disc_q != '0)) disc_d = disc_q - CW'(1);
    end
  end

  // fetch state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= {RESET_PC[XLEN-1:2], 2'b00};
      rsp_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
      out_q    <= '0;
      disc_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;
  assign stall_cnt = stall_q;

  // saturating count of decode-starved cycles; survives redirects
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (bus.dec_ready && !bus.dec_valid && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small in-order imem model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus();

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  int          cyc   = 0;
  int          lat   = 1;
  int          n_req = 0;
  logic [31:0] addr_log[$];
  logic [31:0] fault_addr = 32'hFFFF_FFFF;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] SUB  = 32'h40B5_0533;
  localparam logic [17:0] KEY_ADDI = 18'b0000000_0_000_0010011;
  localparam logic [17:0] KEY_SUB  = 18'b0100000_1_000_0110011;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a[9] ? SUB : ADDI;
  endfunction

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (rst) pend.delete();
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend[0].addr);
        bus.imem_rsp_err   = (pend[0].addr == fault_addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
      end
      @(negedge clk); #3;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
        addr_log.push_back(bus.imem_req_addr);
        n_req++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_dec(input string tag);
    int c = 0;
    while (!bus.dec_valid && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk(tag, {63'd0, bus.dec_valid}, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int got;
    int base;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("rst_dec_valid", {63'd0, bus.dec_valid}, 64'd0);
    chk("rst_dec_instr", {32'd0, bus.dec_instr}, 64'd0);
    chk("rst_dec_key",   {46'd0, bus.dec_key}, 64'd0);
    chk("rst_dec_pc",    {32'd0, bus.dec_pc}, 64'd0);
    chk("rst_dec_fault", {63'd0, bus.dec_fault}, 64'd0);

    // sequential fetch from RESET_PC, decode always ready
    base = addr_log.size();
    @(negedge clk);
    rst = 1'b0;
    bus.dec_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk); #1;
      if (bus.dec_valid) begin
        chk("seq_pc",  {32'd0, bus.dec_pc}, 64'h100 + 64'(4 * got));
        chk("seq_key", {46'd0, bus.dec_key}, {46'd0, KEY_ADDI});
        got++;
      end
    end
    chk("seq_count", 64'(got), 64'd6);
    for (int i = 0; i < 4; i++)
      chk("seq_addr", {32'd0, addr_log[base + i]}, 64'h100 + 64'(4 * i));

    // credit limit: decode stalled, exactly DEPTH requests
    @(negedge clk);
    rst = 1'b1;
    bus.dec_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = n_req;
    repeat (10) @(negedge clk);
    #1;
    chk("full_nreq",      64'(n_req - base), 64'd4);
    chk("full_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("full_head_pc",   {32'd0, bus.dec_pc}, 64'h100);
    @(negedge clk);
    bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    #1;
    chk("full_pop_pc", {32'd0, bus.dec_pc}, 64'h104);
    repeat (5) @(negedge clk);
    #1;
    chk("full_nreq2",     64'(n_req - base), 64'd5);
    chk("full_last_addr", {32'd0, addr_log[addr_log.size() - 1]}, 64'h110);
    chk("full_req_valid2", {63'd0, bus.imem_req_valid}, 64'd0);

    // redirect with 3 outstanding, 3-cycle memory
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lat = 3;
    bus.dec_ready = 1'b1;
    base = n_req;
    repeat (3) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    #1;
    chk("redir_nreq",      64'(n_req - base), 64'd3);
    chk("redir_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    chk("redir_next_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("redir_next_addr",  {32'd0, bus.imem_req_addr}, 64'h200);
    chk("redir_stale0", {63'd0, bus.dec_valid}, 64'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("redir_stale", {63'd0, bus.dec_valid}, 64'd0);
    end
    wait_dec("redir_wait");
    chk("redir_pc",    {32'd0, bus.dec_pc}, 64'h200);
    chk("redir_instr", {32'd0, bus.dec_instr}, {32'd0, SUB});
    chk("redir_key",   {46'd0, bus.dec_key}, {46'd0, KEY_SUB});
    @(negedge clk); #1;
    chk("redir_pc2",   {32'd0, bus.dec_pc}, 64'h204);

    // redirect colliding with a response and a pop
    @(negedge clk);
    rst = 1'b1;
    bus.dec_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lat = 1;
    base = n_req;
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    bus.dec_ready      = 1'b1;
    #1;
    chk("coll_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    chk("coll_head",      {63'd0, bus.dec_valid}, 64'd1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    chk("coll_empty",     {63'd0, bus.dec_valid}, 64'd0);
    chk("coll_empty_pc",  {32'd0, bus.dec_pc}, 64'd0);
    chk("coll_nreq",      64'(n_req - base), 64'd2);
    chk("coll_next_addr", {32'd0, bus.imem_req_addr}, 64'h300);
    wait_dec("coll_wait");
    chk("coll_pc",        {32'd0, bus.dec_pc}, 64'h300);

    // access fault is carried per entry
    @(negedge clk);
    rst = 1'b1;
    bus.dec_ready = 1'b0;
    fault_addr = 32'h0000_0010;
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0010;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    wait_dec("fault_wait");
    chk("fault_pc",    {32'd0, bus.dec_pc}, 64'h10);
    chk("fault_flag",  {63'd0, bus.dec_fault}, 64'd1);
    chk("fault_instr", {32'd0, bus.dec_instr}, {32'd0, ADDI});
    @(negedge clk);
    bus.dec_ready = 1'b1;
    @(negedge clk);
    bus.dec_ready = 1'b0;
    #1;
    chk("fault_next_pc",   {32'd0, bus.dec_pc}, 64'h14);
    chk("fault_next_flag", {63'd0, bus.dec_fault}, 64'd0);

`ifdef FETCH_STALL_CNT_EN
    // stall counter: memory never ready, decode ready, redirect mid-way
    @(negedge clk);
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.dec_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stall_rst", {32'd0, stall_cnt}, 64'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.redirect_valid = (i == 5);
      bus.redirect_pc    = 32'h0000_0400;
    end
    #1;
    chk("stall_cnt", {32'd0, stall_cnt}, 64'd10);
    bus.redirect_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
